// File: rtl/wrr_burst_arbiter.sv
// rtl/wrr_burst_arbiter.sv - weighted round-robin stream arbiter with burst lock
module wrr_burst_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int MaxWeight = 16,
    parameter int WWidth    = $clog2(MaxWeight + 1),
    parameter int IdxWidth  = $clog2(NumIn)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumIn-1:0][WWidth-1:0]      weight_i,
    input  logic [NumIn-1:0]                  valid_i,
    output logic [NumIn-1:0]                  ready_o,
    input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
    input  logic [NumIn-1:0]                  last_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [DataWidth-1:0]              data_o,
    output logic                              last_o,
    output logic [IdxWidth-1:0]               idx_o,
    output logic                              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IdxWidth-1:0]   sel_q, sel_d;
    logic [WWidth-1:0]     cnt_q, cnt_d;
    logic [IdxWidth-1:0]   rr_q, rr_d;

    logic [IdxWidth-1:0]   sel_rr;
    logic [IdxWidth-1:0]   sel;
    logic [WWidth-1:0]     eff_w;
    logic [WWidth-1:0]     rem;
    logic                  hs;

    // Zero means a single beat; anything beyond the maximum quantum is clipped.
    function automatic logic [WWidth-1:0] clip_weight(input logic [WWidth-1:0] w);
        if (w == '0) begin
            return WWidth'(1);
        end else if (w > WWidth'(MaxWeight)) begin
            return WWidth'(MaxWeight);
        end else begin
            return w;
        end
    endfunction

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
        return (i == IdxWidth'(NumIn - 1)) ? '0 : i + IdxWidth'(1);
    endfunction

    // Round-robin search: first valid input at or after rr_q, wrapping; rr_q if none.
    always_comb begin
        int                  idx_int;
        logic [IdxWidth-1:0] cand;
        logic                found;
        sel_rr = rr_q;
        found  = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            idx_int = int'(rr_q) + k;
            if (idx_int >= NumIn) begin
                idx_int = idx_int - NumIn;
            end
            cand = IdxWidth'(idx_int);
            if (!found && valid_i[cand]) begin
                found  = 1'b1;
                sel_rr = cand;
            end
        end
    end

    // State register: reset and flush both return to a clean IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state: lock on stall, enter BURST on a multi-beat quantum, rotate when done.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    if (last_o) begin
                        rr_d = next_idx(sel);
                    end else begin
                        sel_d   = sel;
                        cnt_d   = eff_w - WWidth'(1);
                        state_d = BURST;
                    end
                end else if (valid_o) begin
                    sel_d   = sel;
                    cnt_d   = eff_w;
                    state_d = HOLD;
                end
            end
            HOLD, BURST: begin
                if (hs) begin
                    if (last_o) begin
                        rr_d    = next_idx(sel_q);
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - WWidth'(1);
                        end
                        state_d = BURST;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: combinational mux of the selected input plus per-input ready.
    always_comb begin
        sel     = (state_q == IDLE) ? sel_rr : sel_q;
        eff_w   = clip_weight(weight_i[sel]);
        valid_o = (state_q == IDLE) ? |valid_i : valid_i[sel_q];
        rem     = (state_q == IDLE) ? eff_w : cnt_q;
        hs      = valid_o & ready_i;
        data_o  = data_i[sel];
        idx_o   = sel;
        last_o  = last_i[sel] | (rem == WWidth'(1));
        busy_o  = (state_q != IDLE);
        ready_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            ready_o[i] = hs & (sel == IdxWidth'(i));
        end
    end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb/tb_wrr_burst_arbiter.sv - directed vector bench for wrr_burst_arbiter
module tb_wrr_burst_arbiter;

    localparam int NumIn     = 4;
    localparam int DataWidth = 32;
    localparam int WW        = 5;

    logic                            clk_i = 1'b0;
    logic                            rst_i = 1'b1;
    logic                            flush_i = 1'b0;
    logic [NumIn-1:0][WW-1:0]        weight_i = '0;
    logic [NumIn-1:0]                valid_i = '0;
    logic [NumIn-1:0]                ready_o;
    logic [NumIn-1:0][DataWidth-1:0] data_i = '0;
    logic [NumIn-1:0]                last_i = '0;
    logic                            valid_o;
    logic                            ready_i = 1'b0;
    logic [DataWidth-1:0]            data_o;
    logic                            last_o;
    logic [1:0]                      idx_o;
    logic                            busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wrr_burst_arbiter #(
        .NumIn(NumIn), .DataWidth(DataWidth), .MaxWeight(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .weight_i(weight_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .last_i(last_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
        .idx_o(idx_o), .busy_o(busy_o)
    );

    typedef struct {
        logic        flush;
        logic [19:0] w;
        logic [3:0]  valid;
        logic        ready;
        logic [3:0]  last;
        logic [1:0]  e_idx;
        logic        e_valid;
        logic        e_last;
        logic [3:0]  e_ready;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] wt(input int w3, input int w2, input int w1, input int w0);
        return {5'(w3), 5'(w2), 5'(w1), 5'(w0)};
    endfunction

    function automatic vec_t mk(input logic f, input logic [19:0] w, input logic [3:0] v,
                                input logic r, input logic [3:0] l, input logic [1:0] ei,
                                input logic ev, input logic el, input logic [3:0] er,
                                input logic eb);
        vec_t x;
        x.flush = f; x.w = w; x.valid = v; x.ready = r; x.last = l;
        x.e_idx = ei; x.e_valid = ev; x.e_last = el; x.e_ready = er; x.e_busy = eb;
        return x;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        logic [DataWidth-1:0] exp_data;
        @(negedge clk_i);
        flush_i  = v.flush;
        weight_i = v.w;
        valid_i  = v.valid;
        ready_i  = v.ready;
        last_i   = v.last;
        for (int i = 0; i < NumIn; i++) begin
            data_i[i] = $urandom;
        end
        exp_data = data_i[v.e_idx];
        #1;
        chk("idx_o",   row, 32'(idx_o),   32'(v.e_idx));
        chk("valid_o", row, 32'(valid_o), 32'(v.e_valid));
        chk("last_o",  row, 32'(last_o),  32'(v.e_last));
        chk("ready_o", row, 32'(ready_o), 32'(v.e_ready));
        chk("busy_o",  row, 32'(busy_o),  32'(v.e_busy));
        chk("data_o",  row, data_o,       exp_data);
    endtask

    initial begin
        logic [19:0] wa, w8, w2, w3, w5, w6, w7, w9;
        int row;
        wa = wt(1, 1, 1, 1);
        w8 = wt(1, 1, 1, 8);
        w2 = wt(1, 1, 3, 1);
        w3 = wt(1, 1, 1, 8);
        w5 = wt(1, 4, 1, 1);
        w6 = wt(5, 1, 1, 1);
        w7 = wt(1, 1, 31, 0);
        w9 = wt(1, 1, 1, 3);

        // reset state with nothing valid
        vecs.push_back(mk(0, w8, 4'b0000, 1, 4'b0001, 0, 0, 1, 4'b0000, 0));
        vecs.push_back(mk(0, w8, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, 0));
        // single beats rotate 0,1,2,3,0
        vecs.push_back(mk(0, wa, 4'b1111, 1, 0, 0, 1, 1, 4'b0001, 0));
        vecs.push_back(mk(0, wa, 4'b1111, 1, 0, 1, 1, 1, 4'b0010, 0));
        vecs.push_back(mk(0, wa, 4'b1111, 1, 0, 2, 1, 1, 4'b0100, 0));
        vecs.push_back(mk(0, wa, 4'b1111, 1, 0, 3, 1, 1, 4'b1000, 0));
        vecs.push_back(mk(0, wa, 4'b1111, 1, 0, 0, 1, 1, 4'b0001, 0));
        vecs.push_back(mk(1, wa, 4'b0001, 0, 0, 0, 1, 1, 4'b0000, 0));
        // weighted bursts 1,1,1,2,1,1,1,2
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 0, 4'b0010, 0));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 0, 4'b0010, 1));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 1, 4'b0010, 1));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 2, 1, 1, 4'b0100, 0));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 0, 4'b0010, 0));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 0, 4'b0010, 1));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 1, 1, 1, 4'b0010, 1));
        vecs.push_back(mk(0, w2, 4'b0110, 1, 0, 2, 1, 1, 4'b0100, 0));
        vecs.push_back(mk(1, w2, 4'b0001, 0, 0, 0, 1, 1, 4'b0000, 0));
        // early last on beat 2 of a weight-8 burst
        vecs.push_back(mk(0, w3, 4'b0011, 1, 4'b0000, 0, 1, 0, 4'b0001, 0));
        vecs.push_back(mk(0, w3, 4'b0011, 1, 4'b0001, 0, 1, 1, 4'b0001, 1));
        vecs.push_back(mk(0, w3, 4'b0011, 1, 4'b0000, 1, 1, 1, 4'b0010, 0));
        vecs.push_back(mk(1, w3, 4'b0001, 0, 4'b0000, 0, 1, 0, 4'b0000, 0));
        // backpressure lock in HOLD
        vecs.push_back(mk(0, wa, 4'b0001, 0, 0, 0, 1, 1, 4'b0000, 0));
        vecs.push_back(mk(0, wa, 4'b1001, 0, 0, 0, 1, 1, 4'b0000, 1));
        vecs.push_back(mk(0, wa, 4'b1001, 0, 0, 0, 1, 1, 4'b0000, 1));
        vecs.push_back(mk(0, wa, 4'b1001, 1, 0, 0, 1, 1, 4'b0001, 1));
        vecs.push_back(mk(0, wa, 4'b1001, 1, 0, 3, 1, 1, 4'b1000, 0));
        // mid-burst gaps on idx 2, idx 0 never granted
        vecs.push_back(mk(0, w5, 4'b0100, 1, 0, 2, 1, 0, 4'b0100, 0));
        vecs.push_back(mk(0, w5, 4'b0101, 1, 0, 2, 1, 0, 4'b0100, 1));
        vecs.push_back(mk(0, w5, 4'b0001, 1, 0, 2, 0, 0, 4'b0000, 1));
        vecs.push_back(mk(0, w5, 4'b0001, 1, 0, 2, 0, 0, 4'b0000, 1));
        vecs.push_back(mk(0, w5, 4'b0001, 1, 0, 2, 0, 0, 4'b0000, 1));
        vecs.push_back(mk(0, w5, 4'b0101, 1, 0, 2, 1, 0, 4'b0100, 1));
        vecs.push_back(mk(0, w5, 4'b0101, 1, 0, 2, 1, 1, 4'b0100, 1));
        vecs.push_back(mk(0, w5, 4'b0101, 1, 0, 0, 1, 1, 4'b0001, 0));
        // flush on the second beat of a weight-5 burst on idx 3
        vecs.push_back(mk(0, w6, 4'b1000, 1, 0, 3, 1, 0, 4'b1000, 0));
        vecs.push_back(mk(1, w6, 4'b1111, 1, 0, 3, 1, 0, 4'b1000, 1));
        vecs.push_back(mk(0, w6, 4'b1111, 1, 0, 0, 1, 1, 4'b0001, 0));

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        row = 0;
        foreach (vecs[n]) begin
            apply(vecs[n], row);
            row++;
        end

        // saturation: weight 31 clips to 16 beats, weight 0 acts as 1
        for (int b = 1; b <= 16; b++) begin
            apply(mk(0, w7, 4'b0011, 1, 0, 1, 1, (b == 16), 4'b0010, (b > 1)), row);
            row++;
        end
        apply(mk(0, w7, 4'b0011, 1, 0, 0, 1, 1, 4'b0001, 0), row); row++;
        apply(mk(0, w7, 4'b0011, 1, 0, 1, 1, 0, 4'b0010, 0), row); row++;
        // flush while burst owner is idle: grant held, no transfer
        apply(mk(1, w7, 4'b0001, 0, 0, 1, 0, 0, 4'b0000, 1), row); row++;

        // HOLD then BURST; a weight change mid-burst is ignored
        apply(mk(0, w9, 4'b0001, 0, 0, 0, 1, 0, 4'b0000, 0), row); row++;
        apply(mk(0, w9, 4'b0001, 0, 0, 0, 1, 0, 4'b0000, 1), row); row++;
        apply(mk(0, w9, 4'b0001, 1, 0, 0, 1, 0, 4'b0001, 1), row); row++;
        apply(mk(0, wa, 4'b0001, 1, 0, 0, 1, 0, 4'b0001, 1), row); row++;
        apply(mk(0, wa, 4'b0001, 1, 0, 0, 1, 1, 4'b0001, 1), row); row++;
        apply(mk(0, wa, 4'b0001, 1, 0, 0, 1, 1, 4'b0001, 0), row); row++;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
